seq_checker: RTL and testbench

- Player-input side of the memory game; the counterpart that drives the round counter.
- For the current round number ROUND, it checks ROUND+1 button presses against the stored symbol sequence, positions 0..ROUND.
- Emits a one-cycle round_ok pulse, wired to the round counter's E input, when every press matches.
- Emits a one-cycle lose pulse on a wrong symbol or an input timeout.

---
 rtl/seq_checker_if.sv | 27 ++
 rtl/seq_checker.sv | 103 ++++++++++
 tb/tb_seq_checker.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_checker_if.sv
// Handshake bundle between the memory-game player-input checker and its environment
// (button source, sequence memory, round counter).
interface seq_checker_if #(
    parameter int SIZE  = 4,
    parameter int SYM_W = 2
);
    logic             start;
    logic [SIZE-1:0]  ROUND;
    logic             btn_valid;
    logic [SYM_W-1:0] btn;
    logic [SIZE-1:0]  seq_addr;
    logic [SYM_W-1:0] seq_data;
    logic             busy;
    logic             round_ok;
    logic             lose;
    logic [SIZE-1:0]  idx;

    modport master (
        output start, ROUND, btn_valid, btn, seq_data,
        input  seq_addr, busy, round_ok, lose, idx
    );

    modport slave (
        input  start, ROUND, btn_valid, btn, seq_data,
        output seq_addr, busy, round_ok, lose, idx
    );
endinterface

// File: rtl/seq_checker.sv
// Player-input checker: compares ROUND+1 button presses against the stored symbol
// sequence and emits a one-cycle round_ok or lose pulse.
module seq_checker #(
    parameter int SIZE    = 4,
    parameter int SYM_W   = 2,
    parameter int TIMEOUT = 50000000
) (
    input  logic         clk,
    input  logic         R,
    seq_checker_if.slave bus
);
    localparam int TMR_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_OK   = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    state_t           state_r;
    logic [SIZE-1:0]  idx_r;
    logic [SIZE-1:0]  last_r;
    logic [TMR_W-1:0] timer_r;
    logic             busy_r;
    logic             round_ok_r;
    logic             lose_r;

    logic match_s;
    logic at_last_s;
    logic expired_s;

    assign match_s   = (bus.btn == bus.seq_data);
    assign at_last_s = (idx_r == last_r);
    assign expired_s = (timer_r == TMR_W'(TIMEOUT - 1));

    assign bus.seq_addr = idx_r;
    assign bus.idx      = idx_r;
    assign bus.busy     = busy_r;
    assign bus.round_ok = round_ok_r;
    assign bus.lose     = lose_r;

    // Round FSM; pulses and busy are registered alongside the state they decode.
    always_ff @(posedge clk) begin
        if (R) begin
            state_r    <= ST_IDLE;
            idx_r      <= {SIZE{1'b0}};
            last_r     <= {SIZE{1'b0}};
            timer_r    <= {TMR_W{1'b0}};
            busy_r     <= 1'b0;
            round_ok_r <= 1'b0;
            lose_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    round_ok_r <= 1'b0;
                    lose_r     <= 1'b0;
                    if (bus.start) begin
                        last_r  <= bus.ROUND;
                        idx_r   <= {SIZE{1'b0}};
                        timer_r <= {TMR_W{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= ST_WAIT;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    // A press always wins over a timeout expiring in the same cycle.
                    if (bus.btn_valid) begin
                        if (!match_s) begin
                            lose_r  <= 1'b1;
                            state_r <= ST_FAIL;
                        end else if (at_last_s) begin
                            round_ok_r <= 1'b1;
                            state_r    <= ST_OK;
                        end else begin
                            idx_r   <= idx_r + SIZE'(1);
                            timer_r <= {TMR_W{1'b0}};
                        end
                    end else if (expired_s) begin
                        lose_r  <= 1'b1;
                        state_r <= ST_FAIL;
                    end else begin
                        timer_r <= timer_r + TMR_W'(1);
                    end
                end
                ST_OK, ST_FAIL: begin
                    round_ok_r <= 1'b0;
                    lose_r     <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    round_ok_r <= 1'b0;
                    lose_r     <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_checker.sv
// Scoreboard bench for seq_checker: the driver pushes the outcome predicted by a
// press-list model, the monitor pops it whenever round_ok or lose pulses.
module tb_seq_checker;
    localparam int SIZE    = 4;
    localparam int SYM_W   = 2;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic R;
    always #5 clk = ~clk;

    seq_checker_if #(.SIZE(SIZE), .SYM_W(SYM_W)) bus ();

    logic [SYM_W-1:0] mem [16];
    assign bus.seq_data = mem[bus.seq_addr];

    seq_checker #(.SIZE(SIZE), .SYM_W(SYM_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .R   (R),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [4:0] expq [$];          // {round passed, idx at the pulse}
    int rc_cnt  = 0;               // round counter (data=2) fed by round_ok
    int rc_wins = 0;
    logic prev_pulse = 1'b0;

    int p_gap [16];                // idle cycles before each press
    logic [SYM_W-1:0] p_sym [16];
    int p_n;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every pulse must match the oldest prediction.
    always @(negedge clk) begin
        logic [4:0] e;
        if (R) rc_cnt = 0;
        if (prev_pulse) chk("busy_after_pulse", int'(bus.busy), 0);
        if (bus.round_ok || bus.lose) begin
            chk("pulse_exclusive", int'(bus.round_ok & bus.lose), 0);
            if (expq.size() == 0) begin
                chk("unexpected_pulse", expq.size(), 1);
            end else begin
                e = expq.pop_front();
                chk("outcome_round_ok", int'(bus.round_ok), int'(e[4]));
                chk("outcome_lose", int'(bus.lose), int'(!e[4]));
                chk("outcome_idx", int'(bus.idx), int'(e[3:0]));
                chk("busy_in_pulse", int'(bus.busy), 1);
            end
            if (bus.round_ok) begin
                if (rc_cnt == 2) begin
                    rc_cnt = 0;
                    rc_wins++;
                end else begin
                    rc_cnt++;
                end
            end
        end
        prev_pulse = bus.round_ok | bus.lose;
    end

    // Predict the outcome from the press list, then play it against the DUT.
    task automatic play(input int r);
        int i = 0;
        int n = p_n;
        int idx_e = -1;
        logic ok_e = 1'b0;
        int w = 0;
        for (int k = 0; k < p_n; k++) begin
            if (p_gap[k] >= TIMEOUT) begin n = k; idx_e = i; break; end
            if (p_sym[k] != mem[i]) begin n = k + 1; idx_e = i; break; end
            if (i == r) begin n = k + 1; idx_e = i; ok_e = 1'b1; break; end
            i++;
        end
        if (idx_e < 0) idx_e = i;
        expq.push_back({ok_e, 4'(idx_e)});

        bus.start = 1'b1;
        bus.ROUND = 4'(r);
        tick;
        bus.start = 1'b0;
        for (int k = 0; k < n; k++) begin
            for (int g = 0; g < p_gap[k]; g++) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.ROUND = 4'($urandom_range(0, 15));
                bus.btn   = 2'($urandom_range(0, 3));
                tick;
            end
            bus.start     = 1'b0;
            bus.btn_valid = 1'b1;
            bus.btn       = p_sym[k];
            tick;
            bus.btn_valid = 1'b0;
            if (k < n - 1) begin
                chk("idx_step", int'(bus.idx), k + 1);
                chk("seq_addr_step", int'(bus.seq_addr), k + 1);
            end
        end
        bus.start = 1'b0;
        while (bus.busy && w < 20 * TIMEOUT) begin
            tick;
            w++;
        end
        chk("round_ends", int'(bus.busy), 0);
        tick;
    endtask

    task automatic fill_mem;
        for (int a = 0; a < 16; a++) mem[a] = 2'($urandom_range(0, 3));
    endtask

    task automatic correct_presses(input int r, input int max_gap);
        p_n = r + 1;
        for (int k = 0; k <= r; k++) begin
            p_gap[k] = $urandom_range(0, max_gap);
            p_sym[k] = mem[k];
        end
    endtask

    task automatic do_reset;
        R = 1'b1;
        tick;
        tick;
        R = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int mode;
        int r;
        int pos;
        bus.start = 1'b0;
        bus.ROUND = 4'd0;
        bus.btn_valid = 1'b0;
        bus.btn = 2'd0;
        for (int a = 0; a < 16; a++) mem[a] = 2'd0;
        do_reset;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_idx", int'(bus.idx), 0);
        chk("rst_seq_addr", int'(bus.seq_addr), 0);
        chk("rst_round_ok", int'(bus.round_ok), 0);
        chk("rst_lose", int'(bus.lose), 0);

        // Correct round {1,3,0}, presses on separate cycles.
        mem[0] = 2'd1; mem[1] = 2'd3; mem[2] = 2'd0;
        p_n = 3;
        p_sym[0] = 2'd1; p_sym[1] = 2'd3; p_sym[2] = 2'd0;
        p_gap[0] = 0; p_gap[1] = 1; p_gap[2] = 1;
        play(2);

        // Wrong second press.
        p_n = 2;
        p_sym[0] = 2'd1; p_sym[1] = 2'd2;
        p_gap[0] = 0; p_gap[1] = 0;
        play(2);

        // Timeout with no presses: lose appears after 8 WAIT cycles.
        expq.push_back({1'b0, 4'd0});
        bus.start = 1'b1;
        bus.ROUND = 4'd1;
        tick;
        bus.start = 1'b0;
        repeat (TIMEOUT - 1) tick;
        chk("timeout_not_early", int'(bus.lose), 0);
        chk("timeout_still_busy", int'(bus.busy), 1);
        tick;
        chk("timeout_lose", int'(bus.lose), 1);
        tick;
        chk("timeout_idle", int'(bus.busy), 0);
        tick;

        // Press exactly in the expiry cycle, then finish the round / then time out.
        p_n = 2;
        p_sym[0] = mem[0]; p_sym[1] = mem[1];
        p_gap[0] = TIMEOUT - 1; p_gap[1] = TIMEOUT - 1;
        play(1);
        p_n = 1;
        p_gap[0] = TIMEOUT - 1;
        play(1);

        // Longest round: 16 presses, no wrap.
        fill_mem;
        correct_presses(15, 2);
        play(15);

        // Mid-round reset, start while busy, press while idle.
        fill_mem;
        bus.start = 1'b1;
        bus.ROUND = 4'd3;
        tick;
        bus.start = 1'b0;
        bus.btn_valid = 1'b1;
        bus.btn = mem[0];
        tick;
        bus.btn_valid = 1'b0;
        chk("mid_idx", int'(bus.idx), 1);
        bus.start = 1'b1;
        bus.ROUND = 4'd0;
        tick;
        bus.start = 1'b0;
        chk("start_busy_idx", int'(bus.idx), 1);
        chk("start_busy_busy", int'(bus.busy), 1);
        R = 1'b1;
        tick;
        R = 1'b0;
        chk("mid_rst_idx", int'(bus.idx), 0);
        chk("mid_rst_busy", int'(bus.busy), 0);
        tick;
        bus.btn_valid = 1'b1;
        bus.btn = mem[0];
        tick;
        bus.btn_valid = 1'b0;
        chk("idle_btn_busy", int'(bus.busy), 0);
        chk("idle_btn_idx", int'(bus.idx), 0);
        tick;

        // Round counter with data=2: win on the third round_ok.
        do_reset;
        base = rc_wins;
        for (int n = 0; n < 3; n++) begin
            fill_mem;
            r = $urandom_range(0, 4);
            correct_presses(r, 2);
            play(r);
            if (n < 2) chk("rc_no_win_yet", rc_wins - base, 0);
        end
        chk("rc_win", rc_wins - base, 1);
        chk("rc_back_to_zero", rc_cnt, 0);

        // Randomized rounds.
        for (int n = 0; n < 60; n++) begin
            fill_mem;
            r = $urandom_range(0, 15);
            mode = $urandom_range(0, 4);
            correct_presses(r, (mode == 3) ? TIMEOUT - 1 : 3);
            pos = $urandom_range(0, r);
            if (mode == 1) p_sym[pos] = mem[pos] ^ 2'($urandom_range(1, 3));
            if (mode == 2) p_gap[pos] = TIMEOUT + $urandom_range(0, 3);
            if (mode == 4) p_n = pos;
            play(r);
        end

        repeat (3) tick;
        chk("queue_drained", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
